multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
Control FSM that sequences a multicycle RV32I-subset datapath. The datapath shares one unified instruction/data memory, so each instruction takes several cycles. The block decodes the latched instruction and drives, per cycle, the mux selects, register/memory write enables and ALU operation. It also runs a ready handshake with the shared memory, with a wait-cycle timeout. It replaces the single-cycle control unit when the core moves to a unified memory.

Parameters:
MAX_WAIT, 15, max consecutive cycles a memory state may wait for mem_ready before entering ERROR (1..255)
CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > MAX_WAIT

Ports:
CLK  in  1  clock
rst  in  1  synchronous, active-high reset
op  in  7  Instr[6:0] from instruction register
funct3  in  3  Instr[14:12]
funct7b5  in  1  Instr[30]
Zero  in  1  ALU zero flag
mem_ready  in  1  memory completes the current access this cycle
mem_req  out  1  memory access requested (FETCH, MEMREAD, MEMWRITE)
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register and OldPC enable
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1
ALUSrcB  out  2  00=rs2, 01=ImmExt, 10=const 4
ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
RegWrite  out  1  register file write enable
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
illegal  out  1  sticky: unsupported opcode decoded
timeout  out  1  sticky: memory wait exceeded MAX_WAIT

Behaviour:
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, ERROR. Single registered state plus wait counter.
- Reset (rst=1 at an edge): state<=FETCH, counter<=0, illegal/timeout<=0.
- While rst=1, PCWrite, IRWrite, MemWrite, RegWrite and mem_req are forced to 0. Reset mid-instruction abandons the instruction.
- FETCH: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10. Waits while mem_ready=0. IRWrite=PCWrite=1 only in the cycle mem_ready=1, then go to DECODE.
- DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other op -> ERROR, with illegal<=1.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Next is MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Waits for mem_ready, then MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then FETCH.
- MEMWRITE: mem_req=1, AdrSrc=1, ResultSrc=00. MemWrite held 1 for every cycle in this state, including waits. On mem_ready, go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALU decode. EXECI: same with ALUSrcB=01. Both then go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00. PCWrite=Zero. Then FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Then ALUWB.
- ALU decode (EXECR/EXECI) by funct3:
  - 000: sub iff op[5]&funct7b5, else add
  - 010: slt
  - 110: or
  - 111: and
  - other: add, with illegal<=1 and next state ERROR.
- ImmSrc is combinational from op: lw/I-type 00, sw 01, beq 10, jal 11, else 00.
- Wait counter: cleared on leaving any memory state; increments each cycle mem_ready=0 in a memory state. If it equals MAX_WAIT and mem_ready=0 -> ERROR, timeout<=1. If mem_ready=1 arrives in the same cycle, it wins.
- ERROR: all enables 0, mem_req=0. Stays there until rst.
- Unspecified select outputs are 00 in each state (deterministic, no X).

Decomposition:
- Shared package riscv_ctrl_pkg: state encoding, opcode constants, ALUControl codes, ResultSrc/ALUSrcA/ALUSrcB/ImmSrc codes.
- One combinational sub-module, alu_decoder (ALUOp, funct3, op5, funct7b5 -> ALUControl, bad_funct).
- FSM, wait counter and sticky flags live in multicycle_control.

Test Plan:
- lw, mem_ready always 1 -> FETCH, DECODE, MEMADR, MEMREAD, MEMWB (5 cycles). RegWrite=1 with ResultSrc=01 in cycle 5; IRWrite=1 only in cycle 1.
- sw, mem_ready low for 3 cycles in MEMWRITE -> MemWrite=1 for 4 cycles; FETCH follows; no RegWrite.
- beq with Zero=1, then with Zero=0 -> PCWrite=1 in BEQ cycle, then PCWrite=0; ALUControl=001 both times; 3 cycles each.
- R-type sub (funct3=000, funct7b5=1), then I-type addi with funct7b5=1 -> ALUControl 001, then 000; RegWrite in ALUWB.
- op=0000000 -> DECODE goes to ERROR; illegal=1; enables stay 0 for 10 cycles; rst clears illegal and the next state is FETCH.
- MAX_WAIT=15, mem_ready=0 in FETCH for 16 cycles -> timeout=1 and ERROR. Repeat with mem_ready=1 on the 16th cycle -> normal DECODE, timeout=0.

Source files
------------

// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset control path:
// FSM states, opcodes, ALU operation codes and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_ALUWB, S_BEQ, S_JAL, S_ERROR
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // States that hold a request on the shared memory and may wait for it.
  function automatic logic is_mem_state(state_t s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus funct fields onto ALUControl;
// flags funct3 values the ALU cannot execute.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  aluop_t      aluop,
  input  logic [2:0]  funct3,
  input  logic        op5,
  input  logic        funct7b5,
  output logic [2:0]  alu_control,
  output logic        bad_funct
);

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    alu_control = ALU_ADD;
    bad_funct   = 1'b0;
    case (aluop)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: bad_funct   = 1'b1;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM for a unified-memory RV32I-subset core, with a
// bounded memory ready handshake and sticky illegal/timeout flags.
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [2:0] ALUControl,
  output logic       illegal,
  output logic       timeout
);

  state_t           state, next_state;
  logic [CNT_W-1:0] cnt, cnt_next;
  aluop_t           aluop;
  logic             bad_funct;
  logic             set_illegal, set_timeout;

  alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (ALUControl),
    .bad_funct   (bad_funct)
  );

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state   <= S_FETCH;
      cnt     <= '0;
      illegal <= 1'b0;
      timeout <= 1'b0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
      if (set_illegal) illegal <= 1'b1;
      if (set_timeout) timeout <= 1'b1;
    end
  end

  always_comb begin
    case (op)
      OP_STORE:  ImmSrc = IMM_S;
      OP_BRANCH: ImmSrc = IMM_B;
      OP_JAL:    ImmSrc = IMM_J;
      default:   ImmSrc = IMM_I;
    endcase
  end

  always_comb begin
    next_state  = state;
    cnt_next    = '0;
    set_illegal = 1'b0;
    set_timeout = 1'b0;
    mem_req     = 1'b0;
    PCWrite     = 1'b0;
    AdrSrc      = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    ResultSrc   = RES_ALUOUT;
    ALUSrcA     = SRCA_PC;
    ALUSrcB     = SRCB_RS2;
    aluop       = ALUOP_ADD;

    case (state)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        case (op)
          OP_LOAD, OP_STORE: next_state = S_MEMADR;
          OP_RTYPE:          next_state = S_EXECR;
          OP_ITYPE:          next_state = S_EXECI;
          OP_BRANCH:         next_state = S_BEQ;
          OP_JAL:            next_state = S_JAL;
          default: begin
            next_state  = S_ERROR;
            set_illegal = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = SRCA_RS1;
        ALUSrcB    = SRCB_IMM;
        next_state = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready) next_state = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc  = RES_DATA;
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA     = SRCA_RS1;
        ALUSrcB     = (state == S_EXECI) ? SRCB_IMM : SRCB_RS2;
        aluop       = ALUOP_FUNCT;
        set_illegal = bad_funct;
        next_state  = bad_funct ? S_ERROR : S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        next_state = S_FETCH;
      end
      S_BEQ: begin
        ALUSrcA    = SRCA_RS1;
        aluop      = ALUOP_SUB;
        PCWrite    = Zero;
        next_state = S_FETCH;
      end
      S_JAL: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        PCWrite    = 1'b1;
        next_state = S_ALUWB;
      end
      S_ERROR: next_state = S_ERROR;
      default: next_state = S_ERROR;
    endcase

    // A ready in the final allowed cycle still completes the access.
    if (is_mem_state(state) && !mem_ready) begin
      if (cnt == CNT_W'(MAX_WAIT)) begin
        next_state  = S_ERROR;
        set_timeout = 1'b1;
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end

    if (rst) begin
      mem_req  = 1'b0;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed, table-driven check of multicycle_control: one vector per clock,
// outputs compared mid-cycle against hand-computed values.
module tb_multicycle_control;

  localparam logic [6:0] LW   = 7'b0000011;
  localparam logic [6:0] SW   = 7'b0100011;
  localparam logic [6:0] RT   = 7'b0110011;
  localparam logic [6:0] IT   = 7'b0010011;
  localparam logic [6:0] BEQ  = 7'b1100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] BAD  = 7'b0000000;

  logic       CLK = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = LW;
  logic [2:0] funct3 = 3'b000;
  logic       funct7b5 = 1'b0;
  logic       Zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic       illegal, timeout;

  // {mem_req,PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ImmSrc,RegWrite,ALUControl,illegal,timeout}
  typedef logic [18:0] outs_t;

  typedef struct {
    string      name;
    logic       r;
    logic [6:0] o;
    logic [2:0] f3;
    logic       f7;
    logic       z;
    logic       rdy;
    outs_t      e;
  } vec_t;

  vec_t  vecs[$];
  outs_t got;
  int    n_checks = 0;
  int    n_fail   = 0;

  multicycle_control #(.MAX_WAIT(15), .CNT_W(8)) dut (
    .CLK(CLK), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite),
    .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ImmSrc(ImmSrc), .RegWrite(RegWrite), .ALUControl(ALUControl),
    .illegal(illegal), .timeout(timeout)
  );

  assign got = {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
                ALUSrcB, ImmSrc, RegWrite, ALUControl, illegal, timeout};

  always #5 CLK = ~CLK;

  function automatic outs_t mk(int req, int pcw, int adr, int mw, int irw, int res,
                               int a, int b, int imm, int rw, int alu, int ill, int to);
    return {req[0], pcw[0], adr[0], mw[0], irw[0], res[1:0], a[1:0], b[1:0],
            imm[1:0], rw[0], alu[2:0], ill[0], to[0]};
  endfunction

  function automatic vec_t mkv(string n, int r, logic [6:0] o, int f3, int f7,
                               int z, int rdy, outs_t e);
    vec_t v;
    v.name = n; v.r = r[0]; v.o = o; v.f3 = f3[2:0]; v.f7 = f7[0];
    v.z = z[0]; v.rdy = rdy[0]; v.e = e;
    return v;
  endfunction

  task automatic check(string name, outs_t act, outs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, compare before the rising edge.
  task automatic step(vec_t v);
    @(negedge CLK);
    rst = v.r; op = v.o; funct3 = v.f3; funct7b5 = v.f7; Zero = v.z; mem_ready = v.rdy;
    #2;
    check(v.name, got, v.e);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    rst = 1'b1; mem_ready = 1'b0; op = LW;
    @(negedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    outs_t fwait, ferr;
    fwait = mk(1,0,0,0,0,2,0,2,0,0,0,0,0);

    // reset and lw with ready always high
    vecs.push_back(mkv("rst_hold",      1, LW, 0,0,0,1, mk(0,0,0,0,0,2,0,2,0,0,0,0,0)));
    vecs.push_back(mkv("lw_fetch",      0, LW, 0,0,0,1, mk(1,1,0,0,1,2,0,2,0,0,0,0,0)));
    vecs.push_back(mkv("lw_decode",     0, LW, 0,0,0,1, mk(0,0,0,0,0,0,1,1,0,0,0,0,0)));
    vecs.push_back(mkv("lw_memadr",     0, LW, 0,0,0,1, mk(0,0,0,0,0,0,2,1,0,0,0,0,0)));
    vecs.push_back(mkv("lw_memread",    0, LW, 0,0,0,1, mk(1,0,1,0,0,0,0,0,0,0,0,0,0)));
    vecs.push_back(mkv("lw_memwb",      0, LW, 0,0,0,1, mk(0,0,0,0,0,1,0,0,0,1,0,0,0)));
    // sw with three wait cycles in MEMWRITE
    vecs.push_back(mkv("sw_fetch",      0, SW, 0,0,0,1, mk(1,1,0,0,1,2,0,2,1,0,0,0,0)));
    vecs.push_back(mkv("sw_decode",     0, SW, 0,0,0,1, mk(0,0,0,0,0,0,1,1,1,0,0,0,0)));
    vecs.push_back(mkv("sw_memadr",     0, SW, 0,0,0,1, mk(0,0,0,0,0,0,2,1,1,0,0,0,0)));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mkv("sw_wait",     0, SW, 0,0,0,0, mk(1,0,1,1,0,0,0,0,1,0,0,0,0)));
    vecs.push_back(mkv("sw_done",       0, SW, 0,0,0,1, mk(1,0,1,1,0,0,0,0,1,0,0,0,0)));
    // beq taken, then not taken
    vecs.push_back(mkv("beq1_fetch",    0, BEQ, 0,0,1,1, mk(1,1,0,0,1,2,0,2,2,0,0,0,0)));
    vecs.push_back(mkv("beq1_decode",   0, BEQ, 0,0,1,1, mk(0,0,0,0,0,0,1,1,2,0,0,0,0)));
    vecs.push_back(mkv("beq_taken",     0, BEQ, 0,0,1,1, mk(0,1,0,0,0,0,2,0,2,0,1,0,0)));
    vecs.push_back(mkv("beq0_fetch",    0, BEQ, 0,0,0,1, mk(1,1,0,0,1,2,0,2,2,0,0,0,0)));
    vecs.push_back(mkv("beq0_decode",   0, BEQ, 0,0,0,1, mk(0,0,0,0,0,0,1,1,2,0,0,0,0)));
    vecs.push_back(mkv("beq_not_taken", 0, BEQ, 0,0,0,1, mk(0,0,0,0,0,0,2,0,2,0,1,0,0)));
    // R-type sub, then addi with funct7b5 set (must stay add)
    vecs.push_back(mkv("sub_fetch",     0, RT, 0,1,0,1, mk(1,1,0,0,1,2,0,2,0,0,0,0,0)));
    vecs.push_back(mkv("sub_decode",    0, RT, 0,1,0,1, mk(0,0,0,0,0,0,1,1,0,0,0,0,0)));
    vecs.push_back(mkv("sub_exec",      0, RT, 0,1,0,1, mk(0,0,0,0,0,0,2,0,0,0,1,0,0)));
    vecs.push_back(mkv("sub_wb",        0, RT, 0,1,0,1, mk(0,0,0,0,0,0,0,0,0,1,0,0,0)));
    vecs.push_back(mkv("addi_fetch",    0, IT, 0,1,0,1, mk(1,1,0,0,1,2,0,2,0,0,0,0,0)));
    vecs.push_back(mkv("addi_decode",   0, IT, 0,1,0,1, mk(0,0,0,0,0,0,1,1,0,0,0,0,0)));
    vecs.push_back(mkv("addi_exec",     0, IT, 0,1,0,1, mk(0,0,0,0,0,0,2,1,0,0,0,0,0)));
    vecs.push_back(mkv("addi_wb",       0, IT, 0,1,0,1, mk(0,0,0,0,0,0,0,0,0,1,0,0,0)));
    // remaining ALU decodes: or, slti, andi
    vecs.push_back(mkv("or_fetch",      0, RT, 6,0,0,1, mk(1,1,0,0,1,2,0,2,0,0,0,0,0)));
    vecs.push_back(mkv("or_decode",     0, RT, 6,0,0,1, mk(0,0,0,0,0,0,1,1,0,0,0,0,0)));
    vecs.push_back(mkv("or_exec",       0, RT, 6,0,0,1, mk(0,0,0,0,0,0,2,0,0,0,3,0,0)));
    vecs.push_back(mkv("or_wb",         0, RT, 6,0,0,1, mk(0,0,0,0,0,0,0,0,0,1,0,0,0)));
    vecs.push_back(mkv("slti_fetch",    0, IT, 2,0,0,1, mk(1,1,0,0,1,2,0,2,0,0,0,0,0)));
    vecs.push_back(mkv("slti_decode",   0, IT, 2,0,0,1, mk(0,0,0,0,0,0,1,1,0,0,0,0,0)));
    vecs.push_back(mkv("slti_exec",     0, IT, 2,0,0,1, mk(0,0,0,0,0,0,2,1,0,0,5,0,0)));
    vecs.push_back(mkv("slti_wb",       0, IT, 2,0,0,1, mk(0,0,0,0,0,0,0,0,0,1,0,0,0)));
    vecs.push_back(mkv("andi_fetch",    0, IT, 7,0,0,1, mk(1,1,0,0,1,2,0,2,0,0,0,0,0)));
    vecs.push_back(mkv("andi_decode",   0, IT, 7,0,0,1, mk(0,0,0,0,0,0,1,1,0,0,0,0,0)));
    vecs.push_back(mkv("andi_exec",     0, IT, 7,0,0,1, mk(0,0,0,0,0,0,2,1,0,0,2,0,0)));
    vecs.push_back(mkv("andi_wb",       0, IT, 7,0,0,1, mk(0,0,0,0,0,0,0,0,0,1,0,0,0)));
    // jal
    vecs.push_back(mkv("jal_fetch",     0, JAL, 0,0,0,1, mk(1,1,0,0,1,2,0,2,3,0,0,0,0)));
    vecs.push_back(mkv("jal_decode",    0, JAL, 0,0,0,1, mk(0,0,0,0,0,0,1,1,3,0,0,0,0)));
    vecs.push_back(mkv("jal_exec",      0, JAL, 0,0,0,1, mk(0,1,0,0,0,0,1,2,3,0,0,0,0)));
    vecs.push_back(mkv("jal_wb",        0, JAL, 0,0,0,1, mk(0,0,0,0,0,0,0,0,3,1,0,0,0)));
    // reset in the middle of a load abandons it
    vecs.push_back(mkv("mid_fetch",     0, LW, 0,0,0,1, mk(1,1,0,0,1,2,0,2,0,0,0,0,0)));
    vecs.push_back(mkv("mid_decode",    0, LW, 0,0,0,1, mk(0,0,0,0,0,0,1,1,0,0,0,0,0)));
    vecs.push_back(mkv("rst_mid",       1, LW, 0,0,0,1, mk(0,0,0,0,0,0,2,1,0,0,0,0,0)));
    vecs.push_back(mkv("after_rst",     0, LW, 0,0,0,0, fwait));
    // unsupported funct3 on an R-type
    vecs.push_back(mkv("badf_fetch",    0, RT, 1,0,0,1, mk(1,1,0,0,1,2,0,2,0,0,0,0,0)));
    vecs.push_back(mkv("badf_decode",   0, RT, 1,0,0,1, mk(0,0,0,0,0,0,1,1,0,0,0,0,0)));
    vecs.push_back(mkv("badf_exec",     0, RT, 1,0,0,1, mk(0,0,0,0,0,0,2,0,0,0,0,0,0)));
    vecs.push_back(mkv("badf_error",    0, RT, 1,0,0,1, mk(0,0,0,0,0,0,0,0,0,0,0,1,0)));
    vecs.push_back(mkv("badf_rst",      1, LW, 0,0,0,1, mk(0,0,0,0,0,0,0,0,0,0,0,1,0)));
    // unsupported opcode: ERROR holds with all enables off until reset
    vecs.push_back(mkv("ill_fetch",     0, BAD, 0,0,0,1, mk(1,1,0,0,1,2,0,2,0,0,0,0,0)));
    vecs.push_back(mkv("ill_decode",    0, BAD, 0,0,0,1, mk(0,0,0,0,0,0,1,1,0,0,0,0,0)));
    for (int i = 0; i < 10; i++)
      vecs.push_back(mkv("ill_error",   0, BAD, 0,0,1,1, mk(0,0,0,0,0,0,0,0,0,0,0,1,0)));
    vecs.push_back(mkv("ill_rst",       1, BAD, 0,0,0,1, mk(0,0,0,0,0,0,0,0,0,0,0,1,0)));
    vecs.push_back(mkv("ill_cleared",   0, LW, 0,0,0,0, fwait));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

    // 16 unready fetch cycles: the 16th wait expires the bound
    do_reset();
    for (int i = 0; i < 16; i++) step(mkv("to_wait", 0, LW, 0,0,0,0, fwait));
    ferr = mk(0,0,0,0,0,0,0,0,0,0,0,0,1);
    step(mkv("to_error", 0, LW, 0,0,0,1, ferr));
    step(mkv("to_hold",  0, LW, 0,0,0,1, ferr));

    // ready on the 16th cycle wins over the timeout
    do_reset();
    for (int i = 0; i < 15; i++) step(mkv("late_wait", 0, LW, 0,0,0,0, fwait));
    step(mkv("late_ready",  0, LW, 0,0,0,1, mk(1,1,0,0,1,2,0,2,0,0,0,0,0)));
    step(mkv("late_decode", 0, LW, 0,0,0,1, mk(0,0,0,0,0,0,1,1,0,0,0,0,0)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
